// File: rtl/bcd_key_entry_pkg.sv
// Shared types and constants for the debounced BCD keypad entry buffer.
package bcd_key_entry_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } key_state_t;

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam logic [2:0] MAX_DIGITS = 3'd4;

endpackage

// File: rtl/key_debounce_cnt.sv
// Debounce sample counter plus captured digit and press-stability compare.
// Counter is driven by the owning FSM; o_last flags the final required sample.
module key_debounce_cnt #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_key_valid,
  input  logic [3:0] i_key_bcd,
  input  logic       i_capture,
  input  logic       i_start,
  input  logic       i_inc,
  input  logic       i_clear,
  output logic [3:0] o_cap_digit,
  output logic       o_press_stable,
  output logic       o_last
);

  localparam logic [7:0] LAST_CNT = 8'(DEBOUNCE_CYCLES - 1);

  logic [7:0] r_db_cnt;
  logic [3:0] r_cap_digit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db_cnt    <= 8'd0;
      r_cap_digit <= 4'd0;
    end else begin
      if (i_capture) r_cap_digit <= i_key_bcd;
      if (i_clear)      r_db_cnt <= 8'd0;
      else if (i_start) r_db_cnt <= 8'd1;
      else if (i_inc)   r_db_cnt <= r_db_cnt + 8'd1;
    end
  end

  assign o_cap_digit    = r_cap_digit;
  assign o_press_stable = i_key_valid && (i_key_bcd == r_cap_digit);
  assign o_last         = (r_db_cnt == LAST_CNT);

endmodule

// File: rtl/bcd_key_entry.sv
// Debounced keypad digit entry: FSM accepts one digit per press into a
// four-digit shift buffer with count, full, sticky overflow and a one-cycle strobe.
module bcd_key_entry
  import bcd_key_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_bcd,
  input  logic        key_valid,
  input  logic        clr,
  output logic [15:0] digits,
  output logic [2:0]  count,
  output logic        key_pulse,
  output logic        full,
  output logic        overflow
);

  key_state_t r_state, w_state_nxt;
  logic       w_capture, w_start, w_inc, w_clear, w_accept;
  logic [3:0] w_cap_digit;
  logic       w_press_stable, w_last;

  logic [15:0] r_digits;
  logic [2:0]  r_count;
  logic        r_key_pulse;
  logic        r_overflow;

  key_debounce_cnt #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
    .clk            (clk),
    .rst            (rst),
    .i_key_valid    (key_valid),
    .i_key_bcd      (key_bcd),
    .i_capture      (w_capture),
    .i_start        (w_start),
    .i_inc          (w_inc),
    .i_clear        (w_clear),
    .o_cap_digit    (w_cap_digit),
    .o_press_stable (w_press_stable),
    .o_last         (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_start     = 1'b0;
    w_inc       = 1'b0;
    w_clear     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (key_valid) begin
          w_capture   = 1'b1;
          w_start     = 1'b1;
          w_state_nxt = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (!w_press_stable) begin
          w_clear     = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_last) begin
          w_accept    = 1'b1;
          w_clear     = 1'b1;
          w_state_nxt = HELD;
        end else begin
          w_inc = 1'b1;
        end
      end
      // Digit changes are deliberately ignored here: only release matters.
      HELD: begin
        if (!key_valid) begin
          w_start     = 1'b1;
          w_state_nxt = RELEASE_DB;
        end
      end
      RELEASE_DB: begin
        if (key_valid) begin
          w_clear     = 1'b1;
          w_state_nxt = HELD;
        end else if (w_last) begin
          w_clear     = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_inc = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // clr outranks acceptance; non-BCD codes are dropped before the full check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digits    <= 16'h0000;
      r_count     <= 3'd0;
      r_key_pulse <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_key_pulse <= 1'b0;
      if (clr) begin
        r_digits   <= 16'h0000;
        r_count    <= 3'd0;
        r_overflow <= 1'b0;
      end else if (w_accept && (w_cap_digit <= BCD_MAX)) begin
        if (r_count == MAX_DIGITS) begin
          r_overflow <= 1'b1;
        end else begin
          r_digits    <= {r_digits[11:0], w_cap_digit};
          r_count     <= r_count + 3'd1;
          r_key_pulse <= 1'b1;
        end
      end
    end
  end

  assign digits    = r_digits;
  assign count     = r_count;
  assign key_pulse = r_key_pulse;
  assign overflow  = r_overflow;
  assign full      = (r_count == MAX_DIGITS);

endmodule

// File: tb/tb_bcd_key_entry.sv
// Directed self-checking bench for bcd_key_entry with DEBOUNCE_CYCLES=4.
module tb_bcd_key_entry;
  import bcd_key_entry_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_bcd = 4'd0;
  logic        key_valid = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] digits;
  logic [2:0]  count;
  logic        key_pulse;
  logic        full;
  logic        overflow;

  int checks = 0;
  int failures = 0;
  int pulse_cnt = 0;
  int base;

  bcd_key_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_bcd   (key_bcd),
    .key_valid (key_valid),
    .clr       (clr),
    .digits    (digits),
    .count     (count),
    .key_pulse (key_pulse),
    .full      (full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (key_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] d);
    key_bcd = d;
    key_valid = 1'b1;
    cyc(6);
    key_valid = 1'b0;
    cyc(6);
  endtask

  initial begin
    cyc(2);
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_pulse", 32'(key_pulse), 32'h0);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    rst = 1'b0;
    cyc(1);

    // clean press of 7, held 10 cycles
    base = pulse_cnt;
    key_bcd = 4'd7; key_valid = 1'b1;
    cyc(3);
    chk("clean_pulse_early", 32'(key_pulse), 32'h0);
    cyc(1);
    chk("clean_pulse_lat", 32'(key_pulse), 32'h1);
    chk("clean_digits", 32'(digits), 32'h0007);
    chk("clean_count", 32'(count), 32'h1);
    cyc(1);
    chk("clean_pulse_width", 32'(key_pulse), 32'h0);
    cyc(5);
    key_valid = 1'b0;
    cyc(6);
    chk("clean_one_pulse", 32'(pulse_cnt - base), 32'h1);

    // glitch: 3 samples only
    base = pulse_cnt;
    key_bcd = 4'd2; key_valid = 1'b1;
    cyc(3);
    key_valid = 1'b0;
    cyc(5);
    chk("glitch_pulses", 32'(pulse_cnt - base), 32'h0);
    chk("glitch_digits", 32'(digits), 32'h0007);
    chk("glitch_count", 32'(count), 32'h1);

    // bounce on release
    base = pulse_cnt;
    key_bcd = 4'd3; key_valid = 1'b1;
    cyc(6);
    key_valid = 1'b0; cyc(1);
    key_valid = 1'b1; cyc(1);
    key_valid = 1'b0; cyc(1);
    key_valid = 1'b1; cyc(2);
    key_valid = 1'b0; cyc(6);
    chk("bounce_pulses", 32'(pulse_cnt - base), 32'h1);
    chk("bounce_digits", 32'(digits), 32'h0073);

    // digit change 3->5 inside debounce restarts from 5
    base = pulse_cnt;
    key_bcd = 4'd3; key_valid = 1'b1;
    cyc(2);
    key_bcd = 4'd5;
    cyc(4);
    chk("change_pulse_early", 32'(key_pulse), 32'h0);
    cyc(1);
    chk("change_pulse_lat", 32'(key_pulse), 32'h1);
    chk("change_digits", 32'(digits), 32'h0735);
    key_bcd = 4'd8;
    cyc(3);
    key_valid = 1'b0;
    cyc(6);
    chk("change_held_pulses", 32'(pulse_cnt - base), 32'h1);
    chk("change_count", 32'(count), 32'h3);

    // clear, then fill and overflow
    clr = 1'b1; cyc(1); clr = 1'b0;
    chk("clr_digits", 32'(digits), 32'h0);
    chk("clr_count", 32'(count), 32'h0);
    base = pulse_cnt;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    chk("fill_pulses", 32'(pulse_cnt - base), 32'h4);
    chk("fill_digits", 32'(digits), 32'h1234);
    chk("fill_full", 32'(full), 32'h1);
    chk("fill_ovf", 32'(overflow), 32'h0);
    base = pulse_cnt;
    press(4'd5);
    chk("ovf_pulses", 32'(pulse_cnt - base), 32'h0);
    chk("ovf_digits", 32'(digits), 32'h1234);
    chk("ovf_count", 32'(count), 32'h4);
    chk("ovf_flag", 32'(overflow), 32'h1);
    clr = 1'b1; cyc(1); clr = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'h0);
    chk("clr_full", 32'(full), 32'h0);

    // non-BCD code is discarded
    base = pulse_cnt;
    press(4'hC);
    chk("nonbcd_pulses", 32'(pulse_cnt - base), 32'h0);
    chk("nonbcd_count", 32'(count), 32'h0);
    chk("nonbcd_ovf", 32'(overflow), 32'h0);

    // clr colliding with acceptance
    press(4'd9);
    chk("pre_coll_digits", 32'(digits), 32'h0009);
    key_bcd = 4'd6; key_valid = 1'b1;
    cyc(3);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("coll_count", 32'(count), 32'h0);
    chk("coll_digits", 32'(digits), 32'h0);
    chk("coll_pulse", 32'(key_pulse), 32'h0);
    chk("coll_state", 32'(dut.r_state), 32'(HELD));
    key_valid = 1'b0;
    cyc(6);

    // async reset mid press-debounce
    press(4'd2);
    chk("pre_rst_count", 32'(count), 32'h1);
    key_bcd = 4'd3; key_valid = 1'b1;
    cyc(2);
    #2 rst = 1'b1;
    #1;
    chk("arst_digits", 32'(digits), 32'h0);
    chk("arst_count", 32'(count), 32'h0);
    chk("arst_pulse", 32'(key_pulse), 32'h0);
    chk("arst_state", 32'(dut.r_state), 32'(IDLE));
    #1 rst = 1'b0;
    cyc(3);
    chk("arst_redb_early", 32'(key_pulse), 32'h0);
    cyc(1);
    chk("arst_redb_pulse", 32'(key_pulse), 32'h1);
    chk("arst_redb_digits", 32'(digits), 32'h0003);
    key_valid = 1'b0;
    cyc(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
